// File: rtl/alu_slice_sequencer.sv
// Control stage for a bank of WIDTH 1-bit ALU slices: accepts one operation per
// request handshake, sequences logic ops and multi-pass left shifts, returns the result.
module alu_slice_sequencer #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SHW-1:0]   req_shamt,
    output logic [2:0]       slice_opsel,
    output logic [WIDTH-1:0] slice_op1,
    output logic [WIDTH-1:0] slice_op2,
    output logic             slice_cin0,
    input  logic [WIDTH-1:0] slice_result,
    input  logic             slice_cout_msb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_err
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid, once raised, and its payload stay stable until that transfer.
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_SHL = 3'b101;

    state_t           state_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [2:0]       opsel_q;
    logic [WIDTH-1:0] op1_q;     // doubles as the shift working register
    logic [WIDTH-1:0] op2_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             cout_q;
    logic             err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            opsel_q     <= 3'b000;
            op1_q       <= '0;
            op2_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= req_shamt;
                        cout_q      <= 1'b0;
                        err_q       <= 1'b0;
                        case (req_op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                state_q <= EXEC;
                                opsel_q <= req_op;
                                op1_q   <= req_a;
                                op2_q   <= req_b;
                            end
                            OP_SHL: begin
                                if (req_shamt == '0) begin
                                    state_q     <= DONE;
                                    data_q      <= req_a;
                                    rsp_valid_q <= 1'b1;
                                end else begin
                                    state_q <= SHIFT;
                                    opsel_q <= OP_SHL;
                                    op1_q   <= req_a;
                                    op2_q   <= '0;
                                end
                            end
                            default: begin
                                // Illegal codes never reach the slice opsel bus.
                                state_q     <= DONE;
                                data_q      <= '0;
                                err_q       <= 1'b1;
                                rsp_valid_q <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    state_q     <= DONE;
                    data_q      <= slice_result;
                    cout_q      <= 1'b0;
                    opsel_q     <= 3'b000;
                    op1_q       <= '0;
                    op2_q       <= '0;
                    rsp_valid_q <= 1'b1;
                end
                SHIFT: begin
                    op1_q  <= slice_result;
                    cout_q <= slice_cout_msb;
                    cnt_q  <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q     <= DONE;
                        data_q      <= slice_result;
                        opsel_q     <= 3'b000;
                        op1_q       <= '0;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = data_q;
    assign rsp_cout    = cout_q;
    assign rsp_err     = err_q;
    assign slice_opsel = opsel_q;
    assign slice_op1   = op1_q;
    assign slice_op2   = op2_q;
    assign slice_cin0  = 1'b0;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: behavioural slice bank, directed cases and
// randomized operations checked against an arithmetic reference model.
module tb_alu_slice_sequencer;
    localparam int W   = 8;
    localparam int SHW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [2:0]     req_op = '0;
    logic [W-1:0]   req_a = '0;
    logic [W-1:0]   req_b = '0;
    logic [SHW-1:0] req_shamt = '0;
    logic [2:0]     slice_opsel;
    logic [W-1:0]   slice_op1;
    logic [W-1:0]   slice_op2;
    logic           slice_cin0;
    logic [W-1:0]   slice_result;
    logic           slice_cout_msb;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_data;
    logic           rsp_cout;
    logic           rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    int bad_opsel = 0;
    logic [W+1:0] exp_q[$];

    alu_slice_sequencer #(.WIDTH(W), .SHW(SHW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .slice_opsel(slice_opsel), .slice_op1(slice_op1), .slice_op2(slice_op2),
        .slice_cin0(slice_cin0), .slice_result(slice_result), .slice_cout_msb(slice_cout_msb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Behavioural slice bank; cout is always the MSB of op1 so logic ops must ignore it.
    always_comb begin
        slice_result   = '0;
        slice_cout_msb = slice_op1[W-1];
        case (slice_opsel)
            3'b000: slice_result = slice_op1 & slice_op2;
            3'b001: slice_result = slice_op1 | slice_op2;
            3'b010: slice_result = slice_op1 ^ slice_op2;
            3'b011: slice_result = ~slice_op1;
            3'b101: slice_result = {slice_op1[W-2:0], slice_cin0};
            default: slice_result = '0;
        endcase
    end

    always @(negedge clk)
        if (!(slice_opsel inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101})) bad_opsel++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {err, cout, data}.
    function automatic logic [W+1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [SHW-1:0] sh);
        logic [2*W-1:0] wide;
        case (op)
            3'd0: return {2'b00, a & b};
            3'd1: return {2'b00, a | b};
            3'd2: return {2'b00, a ^ b};
            3'd3: return {2'b00, ~a};
            3'd5: begin
                wide = {{W{1'b0}}, a} << sh;
                return {1'b0, wide[W], wide[W-1:0]};
            end
            default: return {1'b1, 1'b0, {W{1'b0}}};
        endcase
    endfunction

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SHW-1:0] sh, input int hold);
        logic [W+1:0] e;
        int lat_exp, exp_active, n, active;
        exp_q.push_back(ref_model(op, a, b, sh));
        if (op <= 3'd3)                  lat_exp = 2;
        else if (op == 3'd5 && sh != 0)  lat_exp = int'(sh) + 1;
        else                             lat_exp = 1;
        if (op inside {3'd1, 3'd2, 3'd3}) exp_active = 1;
        else if (op == 3'd5)              exp_active = int'(sh);
        else                              exp_active = 0;

        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shamt = sh;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 3'($urandom_range(0, 7)); req_a = W'($urandom); req_b = W'($urandom);
        req_shamt = SHW'($urandom);
        n = 0; active = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            if (slice_opsel != 3'b000) active++;
            @(negedge clk);
            n++;
        end
        check("latency", n, lat_exp - 1);
        check("slice_active_cycles", active, exp_active);
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_req_ready", req_ready, 0);
            check("hold_fields", {rsp_err, rsp_cout, rsp_data}, e);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_fields", {rsp_err, rsp_cout, rsp_data}, e);
        check("no_turnaround", req_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("rsp_err_clear", rsp_err, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    initial begin
        int seen_valid;
        logic [2:0] r_op;
        // Clock/reset block
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_err, rsp_cout, rsp_data}, 0);
        check("rst_slice_bus", {slice_opsel, slice_op1, slice_op2, slice_cin0}, 0);
        rst = 1'b0;

        send(3'b010, 8'hA5, 8'h0F, 3'd0, 0);   // XOR -> 0xAA
        send(3'b101, 8'h81, 8'h00, 3'd3, 0);   // SHL 3 -> 0x08, cout 0
        send(3'b101, 8'h81, 8'h00, 3'd1, 0);   // SHL 1 -> 0x02, cout 1
        send(3'b101, 8'h5C, 8'hFF, 3'd0, 1);   // SHL 0 -> 0x5C
        send(3'b110, 8'h12, 8'h34, 3'd2, 0);   // illegal
        send(3'b011, 8'h3C, 8'h00, 3'd0, 5);   // NOT with backpressure
        send(3'b101, 8'hFF, 8'h00, 3'd7, 0);   // maximum shift

        // Reset in the middle of a long shift.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b101; req_a = 8'hB7; req_shamt = 3'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_shift_opsel", slice_opsel, 3'b101);
        #2 rst = 1'b1;
        #1;
        check("async_rst_req_ready", req_ready, 1);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_fields", {rsp_err, rsp_cout, rsp_data}, 0);
        check("async_rst_slice_bus", {slice_opsel, slice_op1, slice_op2, slice_cin0}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_valid++;
        end
        check("no_rsp_after_abort", seen_valid, 0);
        send(3'b000, 8'hF0, 8'h3C, 3'd0, 0);   // AND -> 0x30

        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            send(r_op, W'($urandom), W'($urandom), SHW'($urandom_range(0, W - 1)),
                 int'($urandom_range(0, 3)));
        end

        check("no_illegal_opsel", bad_opsel, 0);
        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
